// File: rtl/alu_op_sequencer_if.sv
// Host/ALU/result-port bundle for alu_op_sequencer.
// The sequencer binds to the slave modport. The host side (program port, result consumer and ALU) binds to the master modport.
interface alu_op_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3,
  parameter int DATA_W = 8
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [OP_W-1:0]   prog_op;
  logic [ADDR_W:0]   seq_len;
  logic              start;
  logic [OP_W-1:0]   alu_op_code;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_idx;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  prog_we, prog_addr, prog_op, seq_len, start, alu_result, res_ready,
    output alu_op_code, res_data, res_idx, res_valid, busy, done, err
  );

  modport master (
    output prog_we, prog_addr, prog_op, seq_len, start, alu_result, res_ready,
    input  alu_op_code, res_data, res_idx, res_valid, busy, done, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Steps the ALU op_code through a small programmable opcode list.
// Each captured ALU result is offered on a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for start; program writes accepted
// ISSUE   | drive prog[idx] onto alu_op_code
// CAPTURE | ALU settles; result captured at the edge
// HOLD    | result offered; wait for res_ready
// FINISH  | one-cycle done pulse
module alu_op_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst_n,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, FINISH} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t state, state_nxt;

  logic [OP_W-1:0]   prog [DEPTH];
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] idx;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] res_idx_q;
  logic              err_q;

  logic len_ok;
  logic last;
  logic launch;

  assign len_ok = (bus.seq_len != '0) && (bus.seq_len <= DEPTH_L);
  assign last   = ({1'b0, idx} == (len - ONE_L));
  assign launch = (state == IDLE) && bus.start && len_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (bus.res_ready) state_nxt = last ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode straight from state, so an async reset clears them at once.
  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == FINISH);
    bus.res_valid   = (state == HOLD);
    bus.alu_op_code = op_q;
    bus.res_data    = data_q;
    bus.res_idx     = res_idx_q;
    bus.err         = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) prog[i] <= '0;
      len       <= '0;
      idx       <= '0;
      op_q      <= '0;
      data_q    <= '0;
      res_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && bus.start && !len_ok;
      if ((state == IDLE) && bus.prog_we) prog[bus.prog_addr] <= bus.prog_op;
      if (launch) begin
        len <= bus.seq_len;
        idx <= '0;
      end
      if (state == ISSUE) op_q <= prog[idx];
      if (state == CAPTURE) begin
        data_q    <= bus.alu_result;
        res_idx_q <= idx;
      end
      if ((state == HOLD) && bus.res_ready && !last) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU on fixed operands.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [7:0] OPA = 8'h5A;
  localparam logic [7:0] OPB = 8'h33;

  alu_op_sequencer_if #(.ADDR_W(3), .OP_W(3), .DATA_W(8)) bus ();

  alu_op_sequencer #(.DEPTH(8), .ADDR_W(3), .OP_W(3), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational ALU fed by the sequencer's opcode.
  always_comb begin
    case (bus.alu_op_code)
      3'd0:    bus.alu_result = OPA + OPB;
      3'd1:    bus.alu_result = OPA - OPB;
      3'd2:    bus.alu_result = OPA & OPB;
      3'd3:    bus.alu_result = OPA | OPB;
      3'd4:    bus.alu_result = OPA ^ OPB;
      3'd5:    bus.alu_result = ~OPA;
      3'd6:    bus.alu_result = OPA << 1;
      default: bus.alu_result = OPA >> 1;
    endcase
  end

  // Hand-computed results for 0x5A op 0x33, indexed by opcode.
  logic [7:0] exp_data [8] = '{8'h8D, 8'h27, 8'h12, 8'h7B, 8'h69, 8'hA5, 8'hB4, 8'h2D};
  logic [2:0] prog_model [8];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prog_write(input int addr, input logic [2:0] op);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'(addr);
    bus.prog_op   = op;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    prog_model[addr] = op;
  endtask

  // Called at a negedge in IDLE with res_ready=1; checks every cycle of a full run.
  task automatic run_seq(input int n, input bit inject);
    bus.seq_len = 4'(n);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("run_busy", 32'(bus.busy), 32'd1);
    if (inject) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 3'd3;
      bus.prog_op   = 3'b111;
      bus.start     = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.prog_we = 1'b0;
      bus.start   = 1'b0;
      chk("run_op", 32'(bus.alu_op_code), 32'(prog_model[i]));
      chk("run_vld_lo", 32'(bus.res_valid), 32'd0);
      @(negedge clk);
      chk("run_vld_hi", 32'(bus.res_valid), 32'd1);
      chk("run_idx", 32'(bus.res_idx), 32'(i));
      chk("run_data", 32'(bus.res_data), 32'(exp_data[prog_model[i]]));
      @(negedge clk);
      chk("run_vld_drop", 32'(bus.res_valid), 32'd0);
      chk("run_done", 32'(bus.done), (i == n - 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("run_done_end", 32'(bus.done), 32'd0);
    chk("run_busy_end", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 8; i++) prog_model[i] = 3'd0;
    rst_n         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_op   = '0;
    bus.seq_len   = '0;
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    #3;
    chk("rst_op", 32'(bus.alu_op_code), 32'd0);
    chk("rst_data", 32'(bus.res_data), 32'd0);
    chk("rst_vld", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic four-op program with the consumer always ready.
    prog_write(0, 3'b000);
    prog_write(1, 3'b010);
    prog_write(2, 3'b011);
    prog_write(3, 3'b100);
    run_seq(4, 1'b0);

    // Backpressure on slot 1.
    bus.seq_len = 4'd4;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idx0", 32'(bus.res_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_vld", 32'(bus.res_valid), 32'd1);
      chk("bp_idx", 32'(bus.res_idx), 32'd1);
      chk("bp_data", 32'(bus.res_data), 32'h12);
      chk("bp_op", 32'(bus.alu_op_code), 32'd2);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_vld", 32'(bus.res_valid), 32'd0);
    chk("bp_no_early_issue", 32'(bus.alu_op_code), 32'd2);
    @(negedge clk);
    chk("bp_op2", 32'(bus.alu_op_code), 32'd3);
    @(negedge clk);
    chk("bp_idx2", 32'(bus.res_idx), 32'd2);
    chk("bp_data2", 32'(bus.res_data), 32'h7B);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("bp_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("bp_busy_end", 32'(bus.busy), 32'd0);

    // Illegal lengths.
    bus.seq_len = 4'd0;
    bus.start   = 1'b1;
    @(negedge clk);
    chk("err_len0", 32'(bus.err), 32'd1);
    chk("err_len0_busy", 32'(bus.busy), 32'd0);
    bus.seq_len = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_len9", 32'(bus.err), 32'd1);
    chk("err_busy", 32'(bus.busy), 32'd0);
    chk("err_vld", 32'(bus.res_valid), 32'd0);
    chk("err_done", 32'(bus.done), 32'd0);
    chk("err_op_kept", 32'(bus.alu_op_code), 32'd4);
    @(negedge clk);
    chk("err_pulse_end", 32'(bus.err), 32'd0);
    chk("err_still_idle", 32'(bus.busy), 32'd0);

    // Write and start during a run are ignored; an IDLE write takes effect next run.
    run_seq(4, 1'b1);
    prog_write(3, 3'b111);
    run_seq(4, 1'b0);

    // Full depth, then immediate restart from slot 0.
    prog_write(4, 3'b101);
    prog_write(5, 3'b110);
    prog_write(6, 3'b001);
    prog_write(7, 3'b100);
    run_seq(8, 1'b0);
    run_seq(2, 1'b0);

    // Async reset while holding a result.
    bus.res_ready = 1'b0;
    bus.seq_len   = 4'd2;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_hold_vld", 32'(bus.res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_op", 32'(bus.alu_op_code), 32'd0);
    chk("ar_data", 32'(bus.res_data), 32'd0);
    chk("ar_idx", 32'(bus.res_idx), 32'd0);
    chk("ar_vld", 32'(bus.res_valid), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) prog_model[i] = 3'd0;
    run_seq(1, 1'b0);
    run_seq(4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
